plot_scheduler: RTL and testbench

//  Per-frame sequencer and arbiter for the single VGA-adapter write port.
//  On frame_start it resets and runs the full-screen clear plotter (9b x / 8b y sweep).
//  It then shares the write port round-robin among NREQ sprite plotters (coins, player, ...).

---
 rtl/plot_scheduler_if.sv | 39 +++
 rtl/plot_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_plot_scheduler.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plot_scheduler_if.sv
// Write-port and sequencing bundle between plot_scheduler, the clear plotter,
// the sprite plotters and the VGA adapter. The scheduler takes the master side.
interface plot_scheduler_if #(
    parameter int NREQ     = 3,
    parameter int COLOUR_W = 3
);
    logic                     frame_start;
    logic                     clr_rst_n;
    logic                     clr_enable;
    logic                     clr_done;
    logic [8:0]               clr_x;
    logic [7:0]               clr_y;
    logic [NREQ-1:0]          req;
    logic [NREQ-1:0]          req_done;
    logic [9*NREQ-1:0]        req_x;
    logic [8*NREQ-1:0]        req_y;
    logic [COLOUR_W*NREQ-1:0] req_colour;
    logic [NREQ-1:0]          grant;
    logic [8:0]               vga_x;
    logic [7:0]               vga_y;
    logic [COLOUR_W-1:0]      vga_colour;
    logic                     vga_plot;
    logic                     busy;
    logic                     frame_done;

    modport master (
        input  frame_start, clr_done, clr_x, clr_y,
               req, req_done, req_x, req_y, req_colour,
        output clr_rst_n, clr_enable, grant,
               vga_x, vga_y, vga_colour, vga_plot, busy, frame_done
    );

    modport slave (
        output frame_start, clr_done, clr_x, clr_y,
               req, req_done, req_x, req_y, req_colour,
        input  clr_rst_n, clr_enable, grant,
               vga_x, vga_y, vga_colour, vga_plot, busy, frame_done
    );
endinterface

// File: rtl/plot_scheduler.sv
// Per-frame sequencer for the single VGA write port: clears the screen with the
// clear plotter, then hands the port round-robin to the sprite plotters, each at
// most once per frame, and pulses frame_done when everything has been drawn.
module plot_scheduler #(
    parameter int                  NREQ         = 3,
    parameter int                  COLOUR_W     = 3,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = {COLOUR_W{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    plot_scheduler_if.master bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLR_INIT = 3'd1,
        S_CLEAR    = 3'd2,
        S_ARB      = 3'd3,
        S_SERVE    = 3'd4,
        S_FDONE    = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [NREQ-1:0]     grant_r;
    logic [NREQ-1:0]     finished_r;
    logic [PTR_W-1:0]    gidx_r;
    logic [PTR_W-1:0]    rr_ptr_r;
    logic                frame_done_r;

    logic [NREQ-1:0]     pending_s;
    logic [PTR_W-1:0]    pick_s;
    logic                pick_valid_s;
    logic                cur_req_s;
    logic                cur_done_s;
    logic                serve_end_s;
    logic [8:0]          slot_x_s;
    logic [7:0]          slot_y_s;
    logic [COLOUR_W-1:0] slot_colour_s;

    logic                clr_rst_n_s;
    logic                clr_enable_s;
    logic                vga_plot_s;
    logic [8:0]          vga_x_s;
    logic [7:0]          vga_y_s;
    logic [COLOUR_W-1:0] vga_colour_s;

    // Round-robin search of unserved requesters, starting just after the last winner
    always_comb begin
        int idx_v;
        pending_s    = bus.req & ~finished_r;
        pick_valid_s = 1'b0;
        pick_s       = '0;
        idx_v        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            if (int'(rr_ptr_r) + k >= NREQ) begin
                idx_v = int'(rr_ptr_r) + k - NREQ;
            end else begin
                idx_v = int'(rr_ptr_r) + k;
            end
            if (!pick_valid_s && pending_s[PTR_W'(idx_v)]) begin
                pick_valid_s = 1'b1;
                pick_s       = PTR_W'(idx_v);
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Flags and pixel slice of the requester currently holding the grant
    always_comb begin
        cur_req_s     = 1'b0;
        cur_done_s    = 1'b0;
        slot_x_s      = 9'd0;
        slot_y_s      = 8'd0;
        slot_colour_s = {COLOUR_W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (gidx_r == PTR_W'(i)) begin
                cur_req_s     = bus.req[i];
                cur_done_s    = bus.req_done[i];
                slot_x_s      = bus.req_x[9*i +: 9];
                slot_y_s      = bus.req_y[8*i +: 8];
                slot_colour_s = bus.req_colour[COLOUR_W*i +: COLOUR_W];
            end else begin
                cur_req_s = cur_req_s;
            end
        end
    end

    // A serve ends on the last pixel or when the sprite withdraws its request
    assign serve_end_s = !cur_req_s || cur_done_s;

    // Next-state logic of the frame sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.frame_start) begin
                    state_s = S_CLR_INIT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CLR_INIT: state_s = S_CLEAR;
            S_CLEAR: begin
                if (bus.clr_done) begin
                    state_s = S_ARB;
                end else begin
                    state_s = S_CLEAR;
                end
            end
            S_ARB: begin
                if (pick_valid_s) begin
                    state_s = S_SERVE;
                end else begin
                    state_s = S_FDONE;
                end
            end
            S_SERVE: begin
                if (serve_end_s) begin
                    state_s = S_ARB;
                end else begin
                    state_s = S_SERVE;
                end
            end
            S_FDONE: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Write-port source selection and clear-plotter control per state
    always_comb begin
        clr_rst_n_s  = 1'b0;
        clr_enable_s = 1'b0;
        vga_plot_s   = 1'b0;
        vga_x_s      = 9'd0;
        vga_y_s      = 8'd0;
        vga_colour_s = {COLOUR_W{1'b0}};
        case (state_r)
            S_IDLE, S_CLR_INIT: begin
                clr_rst_n_s = 1'b0;
            end
            S_CLEAR: begin
                clr_rst_n_s  = 1'b1;
                clr_enable_s = 1'b1;
                vga_plot_s   = !bus.clr_done;
                vga_x_s      = bus.clr_x;
                vga_y_s      = bus.clr_y;
                vga_colour_s = CLEAR_COLOUR;
            end
            S_SERVE: begin
                // clear plotter stays parked on its done state until the next frame
                clr_rst_n_s  = 1'b1;
                vga_plot_s   = cur_req_s;
                vga_x_s      = slot_x_s;
                vga_y_s      = slot_y_s;
                vga_colour_s = slot_colour_s;
            end
            S_ARB, S_FDONE: begin
                clr_rst_n_s = 1'b1;
            end
            default: begin
                clr_rst_n_s = 1'b0;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant, round-robin pointer, per-frame served mask and end-of-frame pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_r      <= {NREQ{1'b0}};
            gidx_r       <= {PTR_W{1'b0}};
            rr_ptr_r     <= PTR_W'(NREQ - 1);
            finished_r   <= {NREQ{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= (state_s == S_FDONE);
            case (state_r)
                S_CLR_INIT: begin
                    finished_r <= {NREQ{1'b0}};
                end
                S_ARB: begin
                    if (pick_valid_s) begin
                        grant_r  <= {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
                        gidx_r   <= pick_s;
                        rr_ptr_r <= pick_s;
                    end else begin
                        grant_r <= {NREQ{1'b0}};
                    end
                end
                S_SERVE: begin
                    if (serve_end_s) begin
                        finished_r[gidx_r] <= 1'b1;
                        grant_r            <= {NREQ{1'b0}};
                    end else begin
                        grant_r <= grant_r;
                    end
                end
                default: begin
                    grant_r <= grant_r;
                end
            endcase
        end
    end

    assign bus.clr_rst_n  = clr_rst_n_s;
    assign bus.clr_enable = clr_enable_s;
    assign bus.vga_plot   = vga_plot_s;
    assign bus.vga_x      = vga_x_s;
    assign bus.vga_y      = vga_y_s;
    assign bus.vga_colour = vga_colour_s;
    assign bus.grant      = grant_r;
    assign bus.busy       = (state_r != S_IDLE);
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_plot_scheduler.sv
// Testbench for plot_scheduler: behavioural clear and sprite plotters drive the
// scheduler; every written pixel is captured and compared with a frame model.
module tb_plot_scheduler;
    localparam int NREQ     = 3;
    localparam int COLOUR_W = 3;
    localparam int CLR_W    = 16;
    localparam int CLR_H    = 4;
    localparam int CLR_N    = CLR_W * CLR_H;
    localparam int BUDGET   = 2000;

    typedef logic [22:0] pix_t;   // {grant, x, y, colour}

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    plot_scheduler_if #(.NREQ(NREQ), .COLOUR_W(COLOUR_W)) bus ();

    plot_scheduler #(.NREQ(NREQ), .COLOUR_W(COLOUR_W), .CLEAR_COLOUR(3'b000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- clear plotter model (reduced sweep) ----------------
    logic [16:0] clr_cnt;
    logic        clr_done_r;
    logic        clr_stuck;

    always @(posedge clk) begin
        if (!bus.clr_rst_n) begin
            clr_cnt    <= 17'd0;
            clr_done_r <= 1'b0;
        end else if (bus.clr_enable && !clr_done_r) begin
            if (clr_cnt == 17'(CLR_N - 1)) clr_done_r <= 1'b1;
            else clr_cnt <= clr_cnt + 17'd1;
        end
    end
    assign bus.clr_done = clr_done_r | clr_stuck;
    assign bus.clr_x    = 9'(clr_cnt % CLR_W);
    assign bus.clr_y    = 8'(clr_cnt / CLR_W);

    // ---------------- sprite plotter models ----------------
    int              n_px[NREQ];
    int              drop_at[NREQ];
    logic [8:0]      bx[NREQ];
    logic [7:0]      by[NREQ];
    logic [2:0]      col[NREQ];
    logic [NREQ-1:0] req_cfg;
    logic [NREQ-1:0] req_lvl;
    logic            load;
    int              p[NREQ];

    always @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (load) begin
                p[i]       <= 0;
                req_lvl[i] <= req_cfg[i];
            end else if (bus.grant[i] && req_lvl[i]) begin
                p[i] <= p[i] + 1;
                if (drop_at[i] != 0 && p[i] + 1 == drop_at[i]) req_lvl[i] <= 1'b0;
            end
        end
    end

    logic [NREQ-1:0]          rd_s;
    logic [9*NREQ-1:0]        rx_s;
    logic [8*NREQ-1:0]        ry_s;
    logic [COLOUR_W*NREQ-1:0] rc_s;
    always_comb begin
        rd_s = '0;
        rx_s = '0;
        ry_s = '0;
        rc_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            rd_s[i]         = (p[i] == n_px[i] - 1);
            rx_s[9*i +: 9]  = bx[i] + 9'(p[i]);
            ry_s[8*i +: 8]  = by[i] + 8'(p[i]);
            rc_s[3*i +: 3]  = col[i];
        end
    end
    assign bus.req        = req_lvl;
    assign bus.req_done   = rd_s;
    assign bus.req_x      = rx_s;
    assign bus.req_y      = ry_s;
    assign bus.req_colour = rc_s;

    // ---------------- monitor ----------------
    pix_t            got_q[$];
    pix_t            exp_q[$];
    int              gnt_q[$];
    int              expg_q[$];
    int              fd_cnt = 0;
    int              oh_err = 0;
    logic [NREQ-1:0] prev_g = '0;
    int              model_rr;

    function automatic int oh2i(input logic [NREQ-1:0] g);
        for (int i = 0; i < NREQ; i++) if (g[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (bus.vga_plot === 1'b1)
            got_q.push_back({bus.grant, bus.vga_x, bus.vga_y, bus.vga_colour});
        if (bus.grant != '0 && bus.grant != prev_g) gnt_q.push_back(oh2i(bus.grant));
        prev_g <= bus.grant;
        if (bus.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
        if (!$onehot0(bus.grant)) oh_err <= oh_err + 1;
    end

    // ---------------- frame reference model ----------------
    task automatic build_expect(input logic stuck, input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] fin;
        logic [NREQ-1:0] pend;
        int g;
        int cnt;
        exp_q.delete();
        expg_q.delete();
        if (!stuck)
            for (int c = 0; c < CLR_N; c++)
                exp_q.push_back({3'b000, 9'(c % CLR_W), 8'(c / CLR_W), 3'b000});
        fin = '0;
        for (int r = 0; r < NREQ; r++) begin
            pend = mask & ~fin;
            if (pend != '0) begin
                g = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (g < 0 && pend[(model_rr + k) % NREQ]) g = (model_rr + k) % NREQ;
                expg_q.push_back(g);
                cnt = (drop_at[g] != 0) ? drop_at[g] : n_px[g];
                for (int q = 0; q < cnt; q++)
                    exp_q.push_back({3'(1 << g), bx[g] + 9'(q), by[g] + 8'(q), col[g]});
                fin[g]   = 1'b1;
                model_rr = g;
            end
        end
    endtask

    // ---------------- one frame, with optional stray frame_start pulses ----------------
    task automatic run_frame(input logic stuck, input logic [NREQ-1:0] mask, input bit inject,
                             input string tag);
        int   fd_base;
        int   mism;
        pix_t g_bad;
        pix_t e_bad;
        bit   done;
        bit   inj_done;
        clr_stuck = stuck;
        req_cfg   = mask;
        @(negedge clk);
        load = 1'b1;
        got_q.delete();
        gnt_q.delete();
        build_expect(stuck, mask);
        fd_base = fd_cnt;
        @(negedge clk);
        load = 1'b0;
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        n_tests++;
        if ({bus.busy, bus.clr_rst_n, bus.vga_plot} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s clr_init: busy/rst_n/plot=%b expected 100", tag,
                     {bus.busy, bus.clr_rst_n, bus.vga_plot});
        end
        @(negedge clk);
        n_tests++;
        if ({bus.clr_rst_n, bus.clr_enable} !== 2'b11) begin
            n_fail++;
            $display("FAIL %s clear_ctrl: rst_n/enable=%b expected 11", tag,
                     {bus.clr_rst_n, bus.clr_enable});
        end
        done     = 1'b0;
        inj_done = 1'b0;
        for (int k = 0; k < BUDGET && !done; k++) begin
            if (bus.frame_done === 1'b1) begin
                done = 1'b1;
            end else begin
                if (inject && !inj_done && bus.grant != '0) begin
                    bus.frame_start = 1'b1;
                    inj_done = 1'b1;
                end else begin
                    bus.frame_start = 1'b0;
                end
                @(negedge clk);
            end
        end
        bus.frame_start = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: frame_done not seen within %0d cycles", tag, BUDGET);
        end
        if (inject) begin
            bus.frame_start = 1'b1;
            @(negedge clk);
            bus.frame_start = 1'b0;
        end
        repeat (8) @(negedge clk);
        n_tests++;
        if (fd_cnt - fd_base !== 1) begin
            n_fail++;
            $display("FAIL %s frame_done_cycles: got %0d expected 1", tag, fd_cnt - fd_base);
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_after: got %b expected 0", tag, bus.busy);
        end
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s plot_count: got %0d expected %0d", tag, got_q.size(), exp_q.size());
        end
        mism  = 0;
        g_bad = '0;
        e_bad = '0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                if (mism == 0) begin
                    g_bad = got_q[i];
                    e_bad = exp_q[i];
                end
                mism++;
            end
        end
        n_tests++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL %s pixels: %0d wrong, first got %h expected %h", tag, mism, g_bad, e_bad);
        end
        mism = 0;
        for (int i = 0; i < gnt_q.size() && i < expg_q.size(); i++)
            if (gnt_q[i] != expg_q[i]) mism++;
        n_tests++;
        if (gnt_q.size() != expg_q.size() || mism != 0) begin
            n_fail++;
            $display("FAIL %s grant_order: got %0d grants (%0d wrong) expected %0d", tag,
                     gnt_q.size(), mism, expg_q.size());
        end
        n_tests++;
        if (oh_err != 0) begin
            n_fail++;
            $display("FAIL %s grant_onehot: got %0d violations expected 0", tag, oh_err);
        end
        clr_stuck = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int fd_base;
        n_tests++;
        if ({bus.grant, bus.frame_done, bus.clr_rst_n, bus.clr_enable, bus.vga_plot,
             bus.vga_x, bus.vga_y, bus.vga_colour, bus.busy} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_values: got outputs nonzero, expected all 0");
        end
        reset = 1'b0;
        load  = 1'b0;
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        repeat (6) @(negedge clk);
        n_tests++;
        if ({bus.busy, bus.vga_plot} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_pre_clear: busy/plot=%b expected 11", {bus.busy, bus.vga_plot});
        end
        fd_base = fd_cnt;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if ({bus.grant, bus.frame_done, bus.clr_rst_n, bus.clr_enable, bus.vga_plot,
                 bus.vga_x, bus.vga_y, bus.vga_colour, bus.busy} !== 28'd0) begin
                n_fail++;
                $display("FAIL reset_mid_clear: cycle %0d outputs nonzero, expected all 0", c);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        model_rr = NREQ - 1;
        repeat (10) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || fd_cnt != fd_base) begin
            n_fail++;
            $display("FAIL reset_abort: busy=%b frame_done pulses=%0d expected 0 and 0",
                     bus.busy, fd_cnt - fd_base);
        end
    endtask

    task automatic test_clear_only();
        run_frame(1'b0, 3'b000, 1'b0, "clear_only");
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < NREQ; i++) begin
            n_px[i]    = 4;
            drop_at[i] = 0;
            bx[i]      = 9'(20 * i + 3);
            by[i]      = 8'(10 * i + 1);
            col[i]     = 3'(i + 1);
        end
        run_frame(1'b0, 3'b111, 1'b0, "rr_frame1");
        run_frame(1'b0, 3'b111, 1'b0, "rr_frame2");
        n_tests++;
        if (gnt_q.size() == 0 || gnt_q[0] != 0) begin
            n_fail++;
            $display("FAIL rr_restart: first grant %0d expected 0",
                     (gnt_q.size() == 0) ? -1 : gnt_q[0]);
        end
    endtask

    task automatic test_drop();
        drop_at[1] = 2;
        run_frame(1'b0, 3'b111, 1'b0, "req_drop");
        drop_at[1] = 0;
    endtask

    task automatic test_frame_start_ignored();
        run_frame(1'b0, 3'b011, 1'b1, "fs_ignored");
    endtask

    task automatic test_clear_stuck();
        run_frame(1'b1, 3'b010, 1'b0, "clr_stuck");
    endtask

    task automatic test_corner_pixel();
        pix_t hit;
        bit   seen;
        n_px[2] = 1;
        bx[2]   = 9'd319;
        by[2]   = 8'd239;
        col[2]  = 3'b101;
        run_frame(1'b0, 3'b100, 1'b0, "corner");
        seen = 1'b0;
        hit  = '0;
        foreach (got_q[i]) if (!seen && got_q[i][22:20] != 3'b000) begin
            hit  = got_q[i];
            seen = 1'b1;
        end
        n_tests++;
        if (hit !== {3'b100, 9'd319, 8'd239, 3'b101}) begin
            n_fail++;
            $display("FAIL corner_pixel: got %h expected %h", hit, {3'b100, 9'd319, 8'd239, 3'b101});
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] mask;
        logic            stuck;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NREQ; i++) begin
                n_px[i]    = int'($urandom_range(1, 5));
                drop_at[i] = (n_px[i] > 1 && $urandom_range(0, 3) == 0)
                             ? int'($urandom_range(1, n_px[i] - 1)) : 0;
                bx[i]      = 9'($urandom);
                by[i]      = 8'($urandom);
                col[i]     = 3'($urandom);
            end
            mask  = 3'($urandom_range(0, 7));
            stuck = ($urandom_range(0, 5) == 0);
            run_frame(stuck, mask, 1'b0, $sformatf("random%0d", f));
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.frame_start = 1'b0;
        load            = 1'b1;
        req_cfg         = '0;
        clr_stuck       = 1'b0;
        model_rr        = NREQ - 1;
        for (int i = 0; i < NREQ; i++) begin
            n_px[i]    = 1;
            drop_at[i] = 0;
            bx[i]      = 9'd0;
            by[i]      = 8'd0;
            col[i]     = 3'd0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_clear_only();
        test_round_robin();
        test_drop();
        test_frame_start_ignored();
        test_clear_stuck();
        test_corner_pixel();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
